// File: rtl/bcd_updown_counter_if.sv
// Counter-side bundle for the BCD up/down counter.
// Controls flow master->slave, value and flags return.
interface bcd_updown_counter_if #(
   parameter int DIGITS = 3
);
   logic                  EN;
   logic                  UP;
   logic                  DOWN;
   logic                  LOAD;
   logic [4*DIGITS-1:0]   LOAD_VAL;
   logic [4*DIGITS-1:0]   OUT;
   logic                  AT_MAX;
   logic                  AT_ZERO;
   logic                  OVF;
   logic                  UNF;

   modport master (
      output EN,
      output UP,
      output DOWN,
      output LOAD,
      output LOAD_VAL,
      input  OUT,
      input  AT_MAX,
      input  AT_ZERO,
      input  OVF,
      input  UNF
   );

   modport slave (
      input  EN,
      input  UP,
      input  DOWN,
      input  LOAD,
      input  LOAD_VAL,
      output OUT,
      output AT_MAX,
      output AT_ZERO,
      output OVF,
      output UNF
   );
endinterface

// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with ripple carry/borrow,
// clamped load, saturate or wrap at the bounds, and OVF/UNF pulses.
module bcd_updown_counter #(
   parameter int DIGITS = 3,
   parameter int WRAP   = 0
) (
   input logic                  CLOCK,
   input logic                  RESET,
   bcd_updown_counter_if.slave  bus
);

   typedef logic [DIGITS-1:0][3:0] bcd_t;

   bcd_t              q;
   bcd_t              q_nxt;
   bcd_t              inc_val;
   bcd_t              dec_val;
   bcd_t              ld_val;
   logic [DIGITS:0]   cy;
   logic [DIGITS:0]   bw;
   logic              ovf_q;
   logic              unf_q;
   logic              ovf_nxt;
   logic              unf_nxt;
   logic              all9;
   logic              all0;
   logic              sel_ld;
   logic              sel_up;
   logic              sel_dn;

   always_comb begin
      ld_val = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.LOAD_VAL[4*i +: 4] > 4'd9)
            ld_val[i] = 4'd9;
         else
            ld_val[i] = bus.LOAD_VAL[4*i +: 4];
      end
   end

   // cy[i]/bw[i]: every digit below i is at 9/0
   always_comb begin
      inc_val = '0;
      dec_val = '0;
      cy      = '0;
      bw      = '0;
      cy[0]   = 1'b1;
      bw[0]   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         cy[i+1] = cy[i] & (q[i] == 4'd9);
         bw[i+1] = bw[i] & (q[i] == 4'd0);
         if (!cy[i])
            inc_val[i] = q[i];
         else if (q[i] == 4'd9)
            inc_val[i] = 4'd0;
         else
            inc_val[i] = q[i] + 4'd1;
         if (!bw[i])
            dec_val[i] = q[i];
         else if (q[i] == 4'd0)
            dec_val[i] = 4'd9;
         else
            dec_val[i] = q[i] - 4'd1;
      end
   end

   assign all9 = cy[DIGITS];
   assign all0 = bw[DIGITS];

   assign sel_ld = bus.LOAD;
   assign sel_up = ~bus.LOAD & bus.EN & bus.UP & ~bus.DOWN;
   assign sel_dn = ~bus.LOAD & bus.EN & bus.DOWN & ~bus.UP;

   // Full-ripple results already wrap at the bounds; saturate keeps q
   always_comb begin
      q_nxt   = q;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      unique case (1'b1)
         sel_ld: begin
            q_nxt = ld_val;
         end
         sel_up: begin
            ovf_nxt = all9;
            if (!all9 || WRAP != 0)
               q_nxt = inc_val;
         end
         sel_dn: begin
            unf_nxt = all0;
            if (!all0 || WRAP != 0)
               q_nxt = dec_val;
         end
         default: begin
            q_nxt = q;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         q     <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         q     <= q_nxt;
         ovf_q <= ovf_nxt;
         unf_q <= unf_nxt;
      end
   end

   assign bus.OUT     = q;
   assign bus.AT_MAX  = all9;
   assign bus.AT_ZERO = all0;
   assign bus.OVF     = ovf_q;
   assign bus.UNF     = unf_q;

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised N-digit BCD up/down counter with full carry and borrow between digits.
- Successor to the single-digit, non-carrying digit counter; drives score and combo displays in the Dance Dance Revolution game logic.
- Adds a synchronous load, a selectable saturate/wrap mode, an enable, boundary flags, and one-cycle overflow/underflow pulses.
- Output is packed BCD and feeds the 7-segment decoders directly.

Parameters:
- DIGITS, 3, number of BCD digits; legal range 1..8.
- WRAP, 0, 0 = saturate at the bounds, 1 = wrap around modulo 10^DIGITS.

Ports:
- CLOCK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset; clears all state.
- EN  input  1  count enable; gates UP and DOWN only, not LOAD.
- UP  input  1  increment request, sampled each rising edge.
- DOWN  input  1  decrement request, sampled each rising edge.
- LOAD  input  1  synchronous load request.
- LOAD_VAL  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
- OUT  output  4*DIGITS  current packed BCD value; digit 0 in bits [3:0].
- AT_MAX  output  1  high while OUT is all 9s.
- AT_ZERO  output  1  high while OUT is all 0s.
- OVF  output  1  one-cycle pulse on an increment attempted at all 9s.
- UNF  output  1  one-cycle pulse on a decrement attempted at all 0s.

Behaviour:
- State: DIGITS 4-bit registers.
  - Every digit register always holds 0..9.
  - OUT is the registers directly, with no output logic delay.
- Reset (RESET=0, asynchronous): all digits go to 0 and OVF=UNF=0, which gives AT_ZERO=1 and AT_MAX=0. This holds mid-operation too: any in-flight action is discarded.
- Priority per rising edge: LOAD > (EN & UP & ~DOWN) > (EN & DOWN & ~UP) > hold.
  - UP and DOWN both high means hold, with no OVF/UNF.
  - EN=0 means hold unless LOAD is high.
- Load: OUT takes LOAD_VAL on the next edge.
  - Any load digit greater than 9 is clamped to 9, per digit.
  - OVF=UNF=0 on a load cycle.
- Increment:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - The carry ripples combinationally through all digits in the same cycle, so latency is 1 cycle for any carry length (e.g. 099 -> 100 in one edge).
- Decrement:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit, rippling in the same cycle (e.g. 100 -> 099).
- Upper bound (all 9s) with an effective UP:
  - WRAP=0: value holds.
  - WRAP=1: value goes to all 0s.
  - In both modes OVF=1 for exactly the following cycle.
- Lower bound (all 0s) with an effective DOWN:
  - WRAP=0: value holds.
  - WRAP=1: value goes to all 9s.
  - In both modes UNF=1 for exactly the following cycle.
- OVF and UNF are registered.
  - They assert in the same cycle that OUT shows the post-edge value.
  - They deassert on the next edge unless the condition repeats; a held UP at max under WRAP=0 keeps OVF high every cycle.
- AT_MAX and AT_ZERO are decoded combinationally from the registers, glitch-free relative to OUT.
- UP and DOWN are level-sensitive, one step per cycle while held. Edge detection is the caller's responsibility.
- The block has no internal clock gating and no latches. The next-state logic is fully combinational, with every case assigned (no X defaults).

Test Plan:
- Reset/load: assert RESET=0 mid-count, then release, then LOAD=1 with LOAD_VAL=12'h0F9 (DIGITS=3) → OUT=000 and AT_ZERO=1 immediately on reset; after the load edge, OUT=099 (F clamped to 9).
- Carry ripple: OUT=099, EN=1, UP=1 for 1 cycle → OUT=100 after one edge, OVF=0. Then DOWN=1 for 1 cycle → OUT=099.
- Saturate (WRAP=0): load 999, hold UP for 3 cycles → OUT stays 999, AT_MAX=1, OVF=1 in each of the 3 cycles, then 0 after UP drops. Load 000, DOWN=1 → OUT=000, UNF=1 for 1 cycle.
- Wrap (WRAP=1): load 999, UP=1 → OUT=000, OVF=1 for one cycle, AT_ZERO=1. Then DOWN=1 → OUT=999, UNF=1 for one cycle.
- Conflicts: OUT=042 with UP=DOWN=1 → OUT=042. Then EN=0, UP=1 → OUT=042. Then EN=0, LOAD=1, LOAD_VAL=123 → OUT=123. Then LOAD=1 with UP=1 and LOAD_VAL=500 → OUT=500.
- Width: DIGITS=1, WRAP=0, count from 0 to 9 and beyond with UP held for 12 cycles → OUT 0..9, then holds at 9 with OVF=1 for the last 3 cycles. DIGITS=8: load 09999999, UP → 10000000.
